mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multi-cycle control unit for the MIPS datapath. It replaces the single-cycle opcode decoder with a registered state machine that sequences fetch, decode, execute, memory and writeback. It handshakes with a memory port that may stall, and traps on illegal opcodes or memory timeouts. It sits between the instruction register (`opcode`), the ALU (`zero`) and the shared instruction/data memory.

## Interface
- `ALUOP_W`, default 3: width of `alu_op`. Must be ≥3; bits above [2:0] are driven 0.
- `MEM_TIMEOUT`, default 16: maximum number of cycles spent waiting for `mem_ready` in one FETCH or MEM visit.
- `CNT_W`, default 5: wait-counter width. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- `clk` in 1: clock, rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `opcode` in 6: instruction bits [31:26] from the IR. Stable from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable.
- `mem_src_pc` out 1: address source, 1 = PC, 0 = ALU output register.
- `ir_write` out 1: load the IR.
- `pc_write` out 1: load the PC.
- `pc_src` out 2: PC source. 0 = ALU result, 1 = branch target register, 2 = jump target {pc[31:28], imm26, 2'b00}.
- `reg_write` out 1: register-file write.
- `reg_dst` out 2: destination register. 0 = rt, 1 = rd, 2 = $31.
- `wb_src` out 2: writeback data. 0 = ALU register, 1 = memory data register, 2 = PC.
- `alu_src_a` out 1: ALU operand A. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU operand B. 0 = rt, 1 = constant 4, 2 = extended immediate, 3 = immediate<<2.
- `alu_op` out ALUOP_W: ALU operation. 0 ADD, 1 SUB, 2 FUNCT, 3 AND, 4 OR, 5 SLT, 6 SLTU, 7 LUI.
- `state` out 3: current state. FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- `illegal` out 1: sticky flag, set on entry to TRAP from DECODE.
- `timeout` out 1: sticky flag, set on entry to TRAP from a memory wait.

## Operation
- Supported opcodes: R(000000), ADDI, ADDIU, ANDI, ORI, SLTI, SLTIU, LUI, BEQ, BNE, J, JAL, LW, SW. Every other opcode is illegal.
- Extension of the immediate: zero-extended for ANDI/ORI, sign-extended otherwise. This is an external extender selected by opcode.

States and per-state outputs. Every strobe not listed is 0.
- **FETCH**
  - Drive `mem_req`=1 and `mem_src_pc`=1.
  - When `mem_ready`=1: also drive `ir_write`, `pc_write`, `pc_src`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, and go to DECODE.
- **DECODE**
  - Compute the branch target: `alu_src_a`=0, `alu_src_b`=3, ADD.
  - Illegal opcode: go to TRAP and set `illegal`.
  - J: drive `pc_write`, `pc_src`=2, then go to FETCH.
  - JAL: as J, plus `reg_write`, `reg_dst`=2, `wb_src`=2 (the PC already holds PC+4), then go to FETCH.
  - All other supported opcodes: go to EXEC.
- **EXEC**
  - R-type: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=FUNCT, then WB.
  - Immediate ops: `alu_src_a`=1, `alu_src_b`=2, `alu_op` = ADD (ADDI/ADDIU), AND, OR, SLT, SLTU or LUI, then WB.
  - LW/SW: address computed as ADD with the immediate, then MEM.
  - BEQ/BNE: `alu_src_a`=1, `alu_src_b`=0, SUB, `pc_src`=1. `pc_write` = `zero` for BEQ, `!zero` for BNE. Then FETCH.
- **MEM**
  - Drive `mem_req`=1, `mem_src_pc`=0, and `mem_we`=1 for SW.
  - On `mem_ready`: LW goes to WB, SW goes to FETCH.
- **WB**
  - Drive `reg_write`=1.
  - R-type: `reg_dst`=1, `wb_src`=0.
  - Immediate ops: `reg_dst`=0, `wb_src`=0.
  - LW: `reg_dst`=0, `wb_src`=1.
  - Then FETCH.
- **TRAP**
  - All strobes 0. The state holds until `nrst`=0.

Wait counter:
- Cleared on every entry to FETCH or MEM; increments each cycle that `mem_ready`=0.
- When the counter equals MEM_TIMEOUT-1 and `mem_ready`=0, go to TRAP and set `timeout`.
- If `mem_ready`=1 in that same cycle, `mem_ready` wins and no timeout is taken.

## Timing
- Outputs are combinational from the registered state, `opcode`, `zero` and `mem_ready`. The state, counter and flags are registered.
- Reset: the cycle after a rising edge with `nrst`=0 has `state`=FETCH, counter=0, `illegal`=`timeout`=0.
  - While `nrst`=0, every strobe output is forced to 0 and every select output is forced to 0.
  - Reset in any state, including mid-wait in MEM with `mem_we`=1, aborts the operation. No write strobe may be issued in the reset cycle.
- Cycle counts with zero-wait memory (`mem_ready`=1 on the first request cycle):
  - J/JAL: 2 cycles.
  - BEQ/BNE: 3 cycles.
  - SW: 4 cycles.
  - R-type/immediate ops: 4 cycles.
  - LW: 5 cycles.
- Each memory wait cycle adds 1 cycle. `mem_req` stays high and the address select stays stable until `mem_ready`.

## Test plan
- **Reset:** hold `nrst`=0 for 2 cycles with `opcode`=LW → `state`=0, all strobes 0. Release → FETCH asserts `mem_req`=1, `mem_src_pc`=1.
- **R-type, zero-wait:** `opcode`=000000, `mem_ready`=1 → states 0,1,2,4,0. WB shows `reg_write`=1, `reg_dst`=1, `wb_src`=0. 4 cycles total.
- **LW with stall:** `opcode`=100011, `mem_ready` low for 3 cycles in MEM → MEM lasts 4 cycles with `mem_req`=1, `mem_we`=0. WB shows `wb_src`=1, `reg_dst`=0. 8 cycles total.
- **BEQ/BNE:**
  - BEQ with `zero`=1 → `pc_write`=1, `pc_src`=1 in EXEC.
  - BEQ with `zero`=0 → `pc_write`=0.
  - BNE with `zero`=0 → `pc_write`=1.
- **Jumps and illegal opcode:**
  - JAL → DECODE shows `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `wb_src`=2, then FETCH.
  - `opcode`=111111 → TRAP with `illegal`=1, held until reset.
- **Timeout:** MEM_TIMEOUT=16 with `mem_ready` held 0 in FETCH → TRAP after exactly 16 FETCH cycles, `timeout`=1. Repeat with `mem_ready`=1 on the 16th cycle → DECODE, no trap.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB around a
// stallable shared memory port, trapping on illegal opcodes or memory timeouts.
module mips_multicycle_control #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_src_pc,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               timeout
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;
  localparam logic [2:0] ALU_LUI   = 3'd7;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             illegal_reg, illegal_next;
  logic             timeout_reg, timeout_next;

  logic       is_r, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_imm, is_legal;
  logic [2:0] imm_alu_op;
  logic [2:0] alu3;
  logic       wait_expired;

  always_comb begin
    is_r   = (opcode == OP_R);
    is_j   = (opcode == OP_J);
    is_jal = (opcode == OP_JAL);
    is_beq = (opcode == OP_BEQ);
    is_bne = (opcode == OP_BNE);
    is_lw  = (opcode == OP_LW);
    is_sw  = (opcode == OP_SW);
    is_imm = 1'b1;
    imm_alu_op = ALU_ADD;
    case (opcode)
      OP_ADDI, OP_ADDIU: imm_alu_op = ALU_ADD;
      OP_SLTI:           imm_alu_op = ALU_SLT;
      OP_SLTIU:          imm_alu_op = ALU_SLTU;
      OP_ANDI:           imm_alu_op = ALU_AND;
      OP_ORI:            imm_alu_op = ALU_OR;
      OP_LUI:            imm_alu_op = ALU_LUI;
      default:           is_imm = 1'b0;
    endcase
    is_legal = is_r | is_j | is_jal | is_beq | is_bne | is_lw | is_sw | is_imm;
  end

  // The last permitted wait cycle: mem_ready in this same cycle still wins.
  assign wait_expired = (cnt_reg == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = '0;
    illegal_next = illegal_reg;
    timeout_next = timeout_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_src_pc   = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write    = 1'b0;
    reg_dst      = 2'd0;
    wb_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu3         = ALU_ADD;

    case (state_reg)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_src_pc = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'd1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next   = S_TRAP;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        if (!is_legal) begin
          state_next   = S_TRAP;
          illegal_next = 1'b1;
        end else if (is_j || is_jal) begin
          pc_write   = 1'b1;
          pc_src     = 2'd2;
          state_next = S_FETCH;
          if (is_jal) begin
            reg_write = 1'b1;
            reg_dst   = 2'd2;
            wb_src    = 2'd2;
          end
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (is_r) begin
          alu3       = ALU_FUNCT;
          state_next = S_WB;
        end else if (is_imm) begin
          alu_src_b  = 2'd2;
          alu3       = imm_alu_op;
          state_next = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b  = 2'd2;
          state_next = S_MEM;
        end else begin
          alu3       = ALU_SUB;
          pc_src     = 2'd1;
          pc_write   = is_beq ? zero : !zero;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        if (mem_ready) begin
          state_next = is_lw ? S_WB : S_FETCH;
        end else if (wait_expired) begin
          state_next   = S_TRAP;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r ? 2'd1 : 2'd0;
        wb_src     = is_lw ? 2'd1 : 2'd0;
        state_next = S_FETCH;
      end
      default: state_next = S_TRAP;
    endcase

    // Reset aborts any in-flight operation, including a pending store.
    if (!nrst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_src_pc = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      reg_write  = 1'b0;
      reg_dst    = 2'd0;
      wb_src     = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu3       = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= '0;
      illegal_reg <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      illegal_reg <= illegal_next;
      timeout_reg <= timeout_next;
    end
  end

  assign alu_op  = ALUOP_W'(alu3);
  assign state   = state_reg;
  assign illegal = illegal_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: each driven cycle queues the
// expected control word, which is popped and compared on the falling edge.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, src_pc, irw, pcw;
    logic [1:0] pcsrc;
    logic       rw;
    logic [1:0] rdst, wbsrc;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] op;
    logic       ill, to;
  } out_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic       clk, nrst, zero, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, mem_we, mem_src_pc, ir_write, pc_write, reg_write, alu_src_a;
  logic [1:0] pc_src, reg_dst, wb_src, alu_src_b;
  logic [2:0] alu_op, state;
  logic       illegal, timeout;

  mips_multicycle_control #(.ALUOP_W(3), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_src_pc(mem_src_pc), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_src(wb_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .illegal(illegal), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  out_t  obs;
  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  assign obs = {state, mem_req, mem_we, mem_src_pc, ir_write, pc_write, pc_src,
                reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_op, illegal, timeout};

  task automatic check_eq(input string tag, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s state=%0d word=%h", tag, got.st, got);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs, e);
    end
  end

  // Expected control words, written straight from the per-state output table.
  function automatic out_t f_wait();
    out_t e = '0;
    e.st = 3'd0; e.req = 1'b1; e.src_pc = 1'b1;
    return e;
  endfunction
  function automatic out_t f_go();
    out_t e = f_wait();
    e.irw = 1'b1; e.pcw = 1'b1; e.asb = 2'd1; e.op = 3'd0;
    return e;
  endfunction
  function automatic out_t dec();
    out_t e = '0;
    e.st = 3'd1; e.asb = 2'd3;
    return e;
  endfunction
  function automatic out_t ex(input logic [1:0] asb, input logic [2:0] op);
    out_t e = '0;
    e.st = 3'd2; e.asa = 1'b1; e.asb = asb; e.op = op;
    return e;
  endfunction
  function automatic out_t memx(input logic we);
    out_t e = '0;
    e.st = 3'd3; e.req = 1'b1; e.we = we;
    return e;
  endfunction
  function automatic out_t wbx(input logic [1:0] rdst, input logic [1:0] wbsrc);
    out_t e = '0;
    e.st = 3'd4; e.rw = 1'b1; e.rdst = rdst; e.wbsrc = wbsrc;
    return e;
  endfunction
  function automatic out_t trapx(input logic ill, input logic to);
    out_t e = '0;
    e.st = 3'd5; e.ill = ill; e.to = to;
    return e;
  endfunction

  task automatic step(input logic [5:0] op, input logic z, input logic rdy, input logic nr,
                      input bit chk, input string tag, input out_t e);
    opcode = op; zero = z; mem_ready = rdy; nrst = nr;
    if (chk) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, "", '0);
  endtask

  initial begin
    out_t e;
    opcode = OP_LW; zero = 1'b0; mem_ready = 1'b0; nrst = 1'b0;

    // Reset held for two cycles with LW on the opcode bus
    do_reset();
    step(OP_LW, 1'b0, 1'b1, 1'b0, 1'b1, "rst_hold", '0);
    step(OP_LW, 1'b0, 1'b0, 1'b1, 1'b1, "rst_release", f_wait());

    // R-type, zero wait: 0,1,2,4
    do_reset();
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "r_fetch", f_go());
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "r_decode", dec());
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "r_exec", ex(2'd0, 3'd2));
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "r_wb", wbx(2'd1, 2'd0));
    step(OP_R, 1'b0, 1'b0, 1'b1, 1'b1, "r_next_fetch", f_wait());

    // LW with three stall cycles in MEM
    do_reset();
    step(OP_LW, 1'b0, 1'b1, 1'b1, 1'b1, "lw_fetch", f_go());
    step(OP_LW, 1'b0, 1'b1, 1'b1, 1'b1, "lw_decode", dec());
    step(OP_LW, 1'b0, 1'b0, 1'b1, 1'b1, "lw_exec", ex(2'd2, 3'd0));
    for (int i = 0; i < 3; i++)
      step(OP_LW, 1'b0, 1'b0, 1'b1, 1'b1, "lw_mem_stall", memx(1'b0));
    step(OP_LW, 1'b0, 1'b1, 1'b1, 1'b1, "lw_mem_done", memx(1'b0));
    step(OP_LW, 1'b0, 1'b0, 1'b1, 1'b1, "lw_wb", wbx(2'd0, 2'd1));
    step(OP_LW, 1'b0, 1'b0, 1'b1, 1'b1, "lw_next_fetch", f_wait());

    // SW zero wait, then reset aborts a stalled store
    do_reset();
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw_fetch", f_go());
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw_decode", dec());
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw_exec", ex(2'd2, 3'd0));
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw_mem", memx(1'b1));
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw_next_fetch", f_go());
    step(OP_SW, 1'b0, 1'b1, 1'b1, 1'b1, "sw2_decode", dec());
    step(OP_SW, 1'b0, 1'b0, 1'b1, 1'b1, "sw2_exec", ex(2'd2, 3'd0));
    step(OP_SW, 1'b0, 1'b0, 1'b1, 1'b1, "sw2_mem_stall", memx(1'b1));
    e = '0; e.st = 3'd3;
    step(OP_SW, 1'b0, 1'b0, 1'b0, 1'b1, "sw2_abort", e);
    step(OP_SW, 1'b0, 1'b0, 1'b1, 1'b1, "sw2_after_rst", f_wait());

    // Branches: BEQ taken, BEQ not taken, BNE taken
    do_reset();
    for (int b = 0; b < 3; b++) begin
      logic [5:0] bop;
      logic       z;
      bop = (b == 2) ? OP_BNE : OP_BEQ;
      z   = (b == 0);
      e = ex(2'd0, 3'd1); e.pcsrc = 2'd1; e.pcw = (b != 1);
      step(bop, z, 1'b1, 1'b1, 1'b1, "br_fetch", f_go());
      step(bop, z, 1'b1, 1'b1, 1'b1, "br_decode", dec());
      step(bop, z, 1'b1, 1'b1, 1'b1, "br_exec", e);
    end

    // J and JAL complete in DECODE
    step(OP_J, 1'b0, 1'b1, 1'b1, 1'b1, "j_fetch", f_go());
    e = dec(); e.pcw = 1'b1; e.pcsrc = 2'd2;
    step(OP_J, 1'b0, 1'b1, 1'b1, 1'b1, "j_decode", e);
    step(OP_JAL, 1'b0, 1'b1, 1'b1, 1'b1, "jal_fetch", f_go());
    e.rw = 1'b1; e.rdst = 2'd2; e.wbsrc = 2'd2;
    step(OP_JAL, 1'b0, 1'b1, 1'b1, 1'b1, "jal_decode", e);

    // Immediate ops: ORI and LUI
    step(OP_ORI, 1'b0, 1'b1, 1'b1, 1'b1, "ori_fetch", f_go());
    step(OP_ORI, 1'b0, 1'b1, 1'b1, 1'b1, "ori_decode", dec());
    step(OP_ORI, 1'b0, 1'b1, 1'b1, 1'b1, "ori_exec", ex(2'd2, 3'd4));
    step(OP_ORI, 1'b0, 1'b1, 1'b1, 1'b1, "ori_wb", wbx(2'd0, 2'd0));
    step(OP_LUI, 1'b0, 1'b1, 1'b1, 1'b1, "lui_fetch", f_go());
    step(OP_LUI, 1'b0, 1'b1, 1'b1, 1'b1, "lui_decode", dec());
    step(OP_LUI, 1'b0, 1'b1, 1'b1, 1'b1, "lui_exec", ex(2'd2, 3'd7));
    step(OP_LUI, 1'b0, 1'b1, 1'b1, 1'b1, "lui_wb", wbx(2'd0, 2'd0));

    // Illegal opcode traps and holds
    step(OP_BAD, 1'b0, 1'b1, 1'b1, 1'b1, "ill_fetch", f_go());
    step(OP_BAD, 1'b0, 1'b1, 1'b1, 1'b1, "ill_decode", dec());
    step(OP_BAD, 1'b0, 1'b1, 1'b1, 1'b1, "ill_trap", trapx(1'b1, 1'b0));
    step(OP_R,   1'b0, 1'b1, 1'b1, 1'b1, "ill_hold", trapx(1'b1, 1'b0));

    // Timeout: sixteen FETCH cycles without mem_ready
    do_reset();
    for (int i = 0; i < 16; i++)
      step(OP_R, 1'b0, 1'b0, 1'b1, 1'b1, "to_wait", f_wait());
    step(OP_R, 1'b0, 1'b0, 1'b1, 1'b1, "to_trap", trapx(1'b0, 1'b1));
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "to_hold", trapx(1'b0, 1'b1));

    // mem_ready on the sixteenth cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 15; i++)
      step(OP_R, 1'b0, 1'b0, 1'b1, 1'b1, "edge_wait", f_wait());
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "edge_go", f_go());
    step(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, "edge_decode", dec());

    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
